// File: rtl/instr_mem_fetch.sv
// Registered-read instruction memory with valid/ready fetch handshake, program-load
// write port, flush, and alignment/range fault reporting.
module instr_mem_fetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 256,
    parameter int                    BYTE_ADDR  = 1,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = DATA_WIDTH'(32'h00000013),
    localparam int                   IW         = $clog2(DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Req,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic                  Flush,
    input  logic                  Ready,
    output logic [DATA_WIDTH-1:0] Instruction,
    output logic                  Valid,
    output logic                  Fault,
    output logic                  Accept,
    input  logic                  LoadEn,
    input  logic [IW-1:0]         LoadAddr,
    input  logic [DATA_WIDTH-1:0] LoadData
);

    localparam int SHIFT = (BYTE_ADDR != 0) ? $clog2(DATA_WIDTH / 8) : 0;
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((64'd1 << SHIFT) - 64'd1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
    localparam logic [IW:0]           DEPTH_L  = (IW + 1)'(DEPTH);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    fetch_fault;
    logic                    load_ok;

    // Index is compared at full address width so high bits can never alias into range.
    assign idx          = Address >> SHIFT;
    assign misaligned   = |(Address & LOW_MASK);
    assign out_of_range = (idx >= DEPTH_A);
    assign fetch_fault  = misaligned | out_of_range;
    assign load_ok      = ({1'b0, LoadAddr} < DEPTH_L);

    assign Accept = Req & ~Flush & ((state == EMPTY) | Ready);
    assign Valid  = (state == FULL);

    // Load port: contents survive reset; writes past DEPTH are dropped.
    always_ff @(posedge Clk) begin
        if (LoadEn && load_ok) begin
            mem[LoadAddr] <= LoadData;
        end
    end

    // Output stage: a read in the same edge as a load sees the pre-write word.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= EMPTY;
            Fault       <= 1'b0;
            Instruction <= FILL_WORD;
        end else if (Flush) begin
            state <= EMPTY;
            Fault <= 1'b0;
        end else if (Accept) begin
            state <= FULL;
            Fault <= fetch_fault;
            if (fetch_fault) begin
                Instruction <= FILL_WORD;
            end else begin
                Instruction <= mem[idx[IW-1:0]];
            end
        end else if (state == FULL && Ready) begin
            state <= EMPTY;
            Fault <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch: default 32-bit byte-addressed instance plus a
// 16-bit word-addressed DEPTH=10 instance.
module tb_instr_mem_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req = 1'b0, flush = 1'b0, ready = 1'b0, loaden = 1'b0;
    logic [31:0] address = '0, loaddata = '0, instr;
    logic [7:0]  loadaddr = '0;
    logic        valid, fault, accept;

    logic        req2 = 1'b0, loaden2 = 1'b0;
    logic [31:0] address2 = '0;
    logic [3:0]  loadaddr2 = '0;
    logic [15:0] loaddata2 = '0, instr2;
    logic        valid2, fault2, accept2;

    int checks = 0;
    int errors = 0;

    logic [31:0] words [8] = '{32'h12345678, 32'h9ABCDEF0, 32'h2468ACEF, 32'h13579BDF,
                               32'h0F0F0F0F, 32'hF0F0F0F0, 32'h55556666, 32'h77778888};

    always #5 clk = ~clk;

    instr_mem_fetch dut (
        .Clk(clk), .Rst_n(rst_n), .Req(req), .Address(address), .Flush(flush),
        .Ready(ready), .Instruction(instr), .Valid(valid), .Fault(fault),
        .Accept(accept), .LoadEn(loaden), .LoadAddr(loadaddr), .LoadData(loaddata)
    );

    instr_mem_fetch #(
        .DATA_WIDTH(16), .ADDR_WIDTH(32), .DEPTH(10), .BYTE_ADDR(0),
        .FILL_WORD(16'h0013)
    ) dut16 (
        .Clk(clk), .Rst_n(rst_n), .Req(req2), .Address(address2), .Flush(1'b0),
        .Ready(1'b1), .Instruction(instr2), .Valid(valid2), .Fault(fault2),
        .Accept(accept2), .LoadEn(loaden2), .LoadAddr(loadaddr2), .LoadData(loaddata2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0b want 0", fault); end
        checks++; if (instr !== 32'h00000013) begin errors++; $display("FAIL reset_instr got %h want 00000013", instr); end
        checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL reset_valid16 got %0b want 0", valid2); end
        checks++; if (instr2 !== 16'h0013) begin errors++; $display("FAIL reset_instr16 got %h want 0013", instr2); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load;
        for (int i = 0; i < 8; i++) begin
            loaden = 1'b1; loadaddr = 8'(i); loaddata = words[i];
            tick();
        end
        loaden = 1'b0;
    endtask

    task automatic test_back_to_back;
        ready = 1'b1; req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            address = 32'(4 * i);
            #1;
            checks++; if (accept !== 1'b1) begin errors++; $display("FAIL b2b_accept%0d got %0b want 1", i, accept); end
            tick();
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d got %0b want 1", i, valid); end
            checks++; if (fault !== 1'b0) begin errors++; $display("FAIL b2b_fault%0d got %0b want 0", i, fault); end
            checks++; if (instr !== words[i]) begin errors++; $display("FAIL b2b_instr%0d got %h want %h", i, instr, words[i]); end
        end
        req = 1'b0;
        tick();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b want 0", valid); end
    endtask

    task automatic test_stall;
        ready = 1'b1; req = 1'b1; address = 32'd4;
        tick();
        ready = 1'b0; address = 32'd8;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (accept !== 1'b0) begin errors++; $display("FAIL stall_accept%0d got %0b want 0", i, accept); end
            tick();
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d got %0b want 1", i, valid); end
            checks++; if (instr !== 32'h9ABCDEF0) begin errors++; $display("FAIL stall_instr%0d got %h want 9abcdef0", i, instr); end
        end
        ready = 1'b1;
        #1;
        checks++; if (accept !== 1'b1) begin errors++; $display("FAIL stall_release_accept got %0b want 1", accept); end
        tick();
        checks++; if (instr !== 32'h2468ACEF) begin errors++; $display("FAIL stall_release_instr got %h want 2468acef", instr); end
        req = 1'b0;
        tick();
    endtask

    task automatic test_faults;
        logic [31:0] bad [3] = '{32'd6, 32'd1024, 32'hFFFF_FFFC};
        ready = 1'b1; req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            address = bad[i];
            tick();
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL fault_valid%0d got %0b want 1", i, valid); end
            checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_flag%0d got %0b want 1", i, fault); end
            checks++; if (instr !== 32'h00000013) begin errors++; $display("FAIL fault_instr%0d got %h want 00000013", i, instr); end
        end
        address = 32'd0;
        tick();
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear got %0b want 0", fault); end
        checks++; if (instr !== 32'h12345678) begin errors++; $display("FAIL fault_recover_instr got %h want 12345678", instr); end
        req = 1'b0;
        tick();
    endtask

    task automatic test_read_during_write;
        ready = 1'b1; req = 1'b1; address = 32'd8;
        loaden = 1'b1; loadaddr = 8'd2; loaddata = 32'hDEADBEEF;
        tick();
        loaden = 1'b0;
        checks++; if (instr !== 32'h2468ACEF) begin errors++; $display("FAIL rdw_old got %h want 2468acef", instr); end
        tick();
        checks++; if (instr !== 32'hDEADBEEF) begin errors++; $display("FAIL rdw_new got %h want deadbeef", instr); end
        req = 1'b0;
        tick();
    endtask

    task automatic test_flush;
        ready = 1'b0; req = 1'b1; address = 32'd6;
        tick();
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL flush_pre_fault got %0b want 1", fault); end
        flush = 1'b1; address = 32'd0;
        #1;
        checks++; if (accept !== 1'b0) begin errors++; $display("FAIL flush_accept got %0b want 0", accept); end
        tick();
        flush = 1'b0; req = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", valid); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL flush_fault got %0b want 0", fault); end
        ready = 1'b1;
        tick();
    endtask

    task automatic test_async_reset;
        ready = 1'b0; req = 1'b1; address = 32'd4;
        tick();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid got %0b want 1", valid); end
        #2;
        rst_n = 1'b0; req = 1'b0;
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %0b want 0", valid); end
        checks++; if (instr !== 32'h00000013) begin errors++; $display("FAIL areset_instr got %h want 00000013", instr); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL areset_release_valid got %0b want 0", valid); end
        ready = 1'b1; req = 1'b1; address = 32'd12;
        tick();
        checks++; if (instr !== 32'h13579BDF) begin errors++; $display("FAIL areset_retained got %h want 13579bdf", instr); end
        req = 1'b0;
        tick();
    endtask

    task automatic test_narrow;
        logic [3:0]  la [4] = '{4'd9, 4'd2, 4'd1, 4'd12};
        logic [15:0] ld [4] = '{16'hBEEF, 16'h2222, 16'h1111, 16'hDEAD};
        for (int i = 0; i < 4; i++) begin
            loaden2 = 1'b1; loadaddr2 = la[i]; loaddata2 = ld[i];
            tick();
        end
        loaden2 = 1'b0;
        req2 = 1'b1; address2 = 32'd9;
        tick();
        checks++; if (instr2 !== 16'hBEEF) begin errors++; $display("FAIL narrow_idx9 got %h want beef", instr2); end
        checks++; if (fault2 !== 1'b0) begin errors++; $display("FAIL narrow_idx9_fault got %0b want 0", fault2); end
        address2 = 32'd10;
        tick();
        checks++; if (fault2 !== 1'b1) begin errors++; $display("FAIL narrow_idx10_fault got %0b want 1", fault2); end
        checks++; if (instr2 !== 16'h0013) begin errors++; $display("FAIL narrow_idx10_instr got %h want 0013", instr2); end
        address2 = 32'd1;
        tick();
        checks++; if (fault2 !== 1'b0) begin errors++; $display("FAIL narrow_idx1_fault got %0b want 0", fault2); end
        checks++; if (instr2 !== 16'h1111) begin errors++; $display("FAIL narrow_idx1 got %h want 1111", instr2); end
        address2 = 32'd2;
        tick();
        checks++; if (instr2 !== 16'h2222) begin errors++; $display("FAIL narrow_noalias got %h want 2222", instr2); end
        req2 = 1'b0;
        tick();
        checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL narrow_drain got %0b want 0", valid2); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_stall();
        test_faults();
        test_read_during_write();
        test_flush();
        test_async_reset();
        test_narrow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_mem_fetch.md
Name: instr_mem_fetch

Overview:
- Parametrised, registered-read instruction memory. It is the next generation of the single-port instruction ROM.
- Adds the following over the previous block:
  - configurable width, depth and addressing mode
  - a valid/ready fetch handshake with backpressure
  - a program-load write port
  - flush
  - alignment and range fault reporting
- Sits between the PC/fetch stage and the decode stage. The testbench or boot loader fills it through the load port.

Parameters:
- DATA_WIDTH, 32: instruction word width in bits; a multiple of 8, at least 8.
- ADDR_WIDTH, 32: width of the fetch Address port.
- DEPTH, 256: number of words; any value of 2 or more; need not be a power of two.
- BYTE_ADDR, 1: 1 means Address is a byte address (word index = Address >> log2(DATA_WIDTH/8)); 0 means Address is a word index.
- FILL_WORD, 32'h00000013: value driven on Instruction for faulting fetches and after reset (NOP encoding).

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- Req  input  1  fetch request.
- Address  input  ADDR_WIDTH  fetch address; sampled when the request is accepted.
- Flush  input  1  discard any held output and ignore Req this cycle.
- Ready  input  1  downstream can take Instruction this cycle.
- Instruction  output  DATA_WIDTH  fetched word (registered).
- Valid  output  1  Instruction/Fault hold a fetch result.
- Fault  output  1  the held result faulted (misaligned or out of range).
- Accept  output  1  combinational: the request is accepted this cycle.
- LoadEn  input  1  write enable for program load.
- LoadAddr  input  clog2(DEPTH)  word index to write.
- LoadData  input  DATA_WIDTH  word to write.

Behaviour:
- Reset:
  - Rst_n low forces Valid=0, Fault=0, Instruction=FILL_WORD immediately, without waiting for a clock edge.
  - Memory contents are not cleared by reset; they are retained.
  - Reset released mid-operation: the first cycle after release behaves as empty (Valid=0).
- Accept = Req & ~Flush & (~Valid | Ready).
- Fetch latency: 1 cycle. A request accepted at edge N presents its result after edge N, with Valid=1.
- Throughput: 1 fetch per cycle when Ready is held high.
- Index:
  - BYTE_ADDR=1: idx = Address >> log2(DATA_WIDTH/8).
  - BYTE_ADDR=0: idx = Address.
  - The full-width comparison is used; upper address bits are never truncated.
- Misaligned: BYTE_ADDR=1 and any of the low log2(DATA_WIDTH/8) bits of Address are nonzero. This term is always 0 when BYTE_ADDR=0.
- Out of range: idx >= DEPTH.
- On accept:
  - Instruction <= misaligned|out-of-range ? FILL_WORD : mem[idx].
  - Fault <= misaligned|out-of-range.
  - Valid <= 1.
  - Memory is never read at a faulting index.
- Valid & ~Ready & ~Flush (stall): Instruction, Fault and Valid hold exactly. Req is not accepted.
- Valid & Ready & ~Accept: Valid <= 0 and Fault <= 0; Instruction holds its last value.
- Flush (higher priority than everything except reset):
  - Valid <= 0 and Fault <= 0 next edge.
  - Req in the same cycle is dropped and Accept=0.
  - A load in the same cycle still happens.
- Load: on each edge with LoadEn=1, mem[LoadAddr] <= LoadData.
  - LoadAddr >= DEPTH is ignored; it causes no write and no aliasing.
  - Independent of the handshake; allowed every cycle.
- Read-during-write, same index, same edge: the fetch returns the old (pre-write) contents. The next fetch returns the new data.
- Internal state: a two-state output FSM, EMPTY (Valid=0) and FULL (Valid=1).
  - EMPTY -> FULL on Accept.
  - FULL -> FULL on Accept, or on stall.
  - FULL -> EMPTY on (Ready & ~Accept) | Flush.
  - EMPTY -> EMPTY on Flush, or when there is no Req.
- No X may propagate to Instruction: uninitialised words read as whatever was loaded; the bench must load before fetching.

Test Plan:
1. Load words 0..7 = 32'h12345678, 32'h9ABCDEF0, ..., 32'h77778888. Then, with Ready=1, fetch byte addresses 0,4,8,12 back-to-back -> Valid high for 4 consecutive cycles starting 1 cycle after the first Req; Instruction = 12345678, 9ABCDEF0, 2468ACEF, 13579BDF; Fault=0.
2. Fetch address 4 with Ready=0 for 3 cycles, Req held on address 8 -> Instruction stays 9ABCDEF0 with Valid=1 and Accept=0. Raise Ready -> next cycle Instruction=2468ACEF.
3. Fetch address 6 (misaligned), then address 4*DEPTH (out of range), then 32'hFFFF_FFFC -> each gives Valid=1, Fault=1, Instruction=00000013. Then fetch address 0 -> Fault=0, Instruction=12345678.
4. Same edge: LoadEn on LoadAddr=2 with 32'hDEADBEEF, plus fetch of byte address 8 -> returns 2468ACEF. Fetch address 8 again -> DEADBEEF.
5. Valid held with Ready=0; assert Flush together with Req on address 0 -> next cycle Valid=0, Fault=0, and the request is not accepted (Accept=0).
6. Pull Rst_n low mid-stream, between clock edges -> Valid=0 and Instruction=00000013 immediately. After release, fetch address 12 -> 13579BDF (memory retained). Repeat with BYTE_ADDR=0, DATA_WIDTH=16, DEPTH=10: word index 9 returns its loaded value; index 10 faults.
